bcd_scan_controller: RTL
========================

// Module: bcd_scan_controller
// PURPOSE
// - Sequential binary-to-BCD converter and display scanner for the board's seven-segment path.
// - Accepts a BIN_W-bit binary value over a valid/ready handshake and converts it with a
//   shift-add-3 (double-dabble) algorithm, one bit per cycle.
// - Holds the converted digits and time-multiplexes them onto one shared char_7seg decoder,
//   driving a one-hot digit enable.
// - Sits between switch/debounce logic and the display decoder; replaces hard-wired
//   compare/mux conversion.
// PARAMETERS
// - BIN_W     8      width of the binary input; also the number of conversion iterations.
// - DIGITS    3      number of BCD digits held and scanned (>=1).
// - SCAN_DIV  50000  clock cycles per digit slot (>=2); 1 ms per slot at 50 MHz.
// PORTS
// - fr_CLOCK_50  in   1          single clock; all state on rising edge.
// - fr_KEY0      in   1          reset, asynchronous, active-low.
// - in_valid     in   1          in_bin holds a value to convert.
// - in_ready     out  1          controller idle; a value is accepted when in_valid & in_ready.
// - in_bin       in   BIN_W      unsigned binary value.
// - done         out  1          one-cycle pulse; conversion finished, display registers updated.
// - ovf          out  1          last value was >= 10**DIGITS; only the low DIGITS digits are kept.
// - bcd_out      out  4*DIGITS   held BCD result; digit 0 (ones) in [3:0]. Unblanked.
// - dig_bcd      out  4          code for the shared char_7seg; 4'hF = blank.
// - dig_en_n     out  DIGITS     active-low one-hot digit enable; bit i = digit i.
// BEHAVIOUR
// - Reset values (async on fr_KEY0 low):
//   - state=IDLE, in_ready=1, done=0, ovf=0, bcd_out=0.
//   - Scan index=0, prescaler=0, dig_en_n = all ones except bit 0 low, dig_bcd=4'h0.
//   - The display shows a single "0".
// - FSM IDLE -> SHIFT -> DONE -> IDLE:
//   - IDLE: in_ready=1. On in_valid, latch in_bin into the shift register, clear the BCD
//     scratch, set iteration count=0, go to SHIFT.
//   - SHIFT: in_ready=0, for exactly BIN_W cycles. Each cycle: add 3 to every scratch nibble
//     >=5, then shift {scratch, bin} left by 1. After the BIN_W-th cycle, go to DONE.
//   - DONE: in_ready=0. done=1 for this cycle only; bcd_out, ovf and the display registers
//     load in this cycle. Go to IDLE.
// - Timing:
//   - Latency: accept at edge T -> done high in the cycle after edge T+BIN_W+1.
//   - Back-to-back throughput: one value per BIN_W+2 cycles.
// - Width rule:
//   - The scratch register is wide enough for BIN_W bits (ceil(BIN_W*log10(2)) digits, plus
//     one spare).
//   - ovf=1 when any scratch nibble above DIGITS-1 is nonzero; the upper digits are discarded.
// - Leading-zero blanking:
//   - Display digit i (i>0) = 4'hF if it and all higher digits are 0.
//   - Digit 0 is never blank.
//   - bcd_out itself is not blanked.
// - Handshake:
//   - in_valid while in_ready=0 is ignored, with no queuing.
//   - The requester holds in_valid; the value present at the accept edge is the one converted.
// - Scan:
//   - The prescaler counts 0..SCAN_DIV-1 independently of the FSM.
//   - On wrap, the scan index advances i -> i+1, with DIGITS-1 -> 0.
//   - dig_en_n and dig_bcd are registered and change only on wrap.
//   - The display keeps showing the previous value throughout SHIFT, so there is no tearing.
//   - The new value appears from the next slot boundary after DONE.
// - Reset mid-conversion: aborts; all state returns to its reset values; no done pulse.
// - Simultaneous DONE and scan wrap: the wrap selects the index from the new display
//   registers loaded in the same edge, i.e. the new value.
// STRUCTURE
// - Shared package/include disp_defs:
//   - BLANK_CODE = 4'hF.
//   - State encodings ST_IDLE / ST_SHIFT / ST_DONE.
//   - Function clog2 for counter widths.
// - One sub-module, dd_bcd_step: combinational add-3-per-nibble plus shift for one iteration,
//   parameterised on scratch width.
// - FSM, iteration counter, prescaler, scan index, blanking logic and output registers live
//   in the top level.
// TESTING (SCAN_DIV=4 in sim; BIN_W=8, DIGITS=3 unless noted)
// - Reset release, no input:
//   - Expect in_ready=1, bcd_out=12'h000.
//   - dig_en_n cycles 110 -> 101 -> 011 every 4 clocks.
//   - dig_bcd cycles 0 -> F -> F.
// - Accept in_bin=8'd255:
//   - done pulses exactly 9 cycles after the accept edge; bcd_out=12'h255, ovf=0.
//   - dig_bcd sequence over the scan is 5, 5, 2.
// - Accept 8'd7, then 8'd0:
//   - 7 gives display 7, F, F.
//   - 0 gives bcd_out=0 and display 0, F, F; digit 0 is never blank.
// - Pulse in_valid with 8'd99 during SHIFT of 8'd128:
//   - Ignored: one done pulse only, bcd_out=12'h128.
// - Drop fr_KEY0 for 1 cycle at SHIFT iteration 4:
//   - No done pulse; state returns to reset values; in_ready=1 the next cycle.
// - DIGITS=2 with in_bin=8'd200:
//   - ovf=1, bcd_out=8'h00.
//   - Display shows 0 followed by a blank.

Source files
------------

// File: rtl/bcd_scan_controller_pkg.sv
// Shared definitions for the BCD scan controller: state encodings, blank code and
// width helpers.
package bcd_scan_controller_pkg;

   localparam logic [3:0] BLANK_CODE = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Bits needed to hold 0..value-1; never less than 1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w = 1;
      while ((64'd1 << w) < 64'(value)) w++;
      return w;
   endfunction

   // Decimal digits of 2**bin_w-1 plus one spare, and at least as many as are displayed.
   function automatic int unsigned scratch_digits(input int unsigned bin_w,
                                                  input int unsigned digits);
      longint unsigned max_val;
      int unsigned     n;
      max_val = (64'd1 << bin_w) - 64'd1;
      n = 1;
      while (max_val >= 64'd10) begin
         n++;
         max_val = max_val / 64'd10;
      end
      return (n + 1 > digits) ? n + 1 : digits;
   endfunction

endpackage

// File: rtl/bcd_scan_controller_if.sv
// Conversion handshake plus held-result and display-scan outputs of the BCD scan controller.
interface bcd_scan_controller_if #(
   parameter int unsigned BIN_W  = 8,
   parameter int unsigned DIGITS = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [BIN_W-1:0]      in_bin;
   logic                  done;
   logic                  ovf;
   logic [4*DIGITS-1:0]   bcd_out;
   logic [3:0]            dig_bcd;
   logic [DIGITS-1:0]     dig_en_n;

   modport master (
      output in_valid, in_bin,
      input  in_ready, done, ovf, bcd_out, dig_bcd, dig_en_n
   );

   modport slave (
      input  in_valid, in_bin,
      output in_ready, done, ovf, bcd_out, dig_bcd, dig_en_n
   );
endinterface

// File: rtl/bcd_scan_controller_dd_bcd_step.sv
// One double-dabble iteration: add 3 to every scratch nibble >= 5, then shift
// {scratch, bin} left by one.
module bcd_scan_controller_dd_bcd_step #(
   parameter int unsigned SCR_W = 16,
   parameter int unsigned BIN_W = 8
) (
   input  logic [SCR_W-1:0] scratch,
   input  logic [BIN_W-1:0] bin,
   output logic [SCR_W-1:0] scratch_next,
   output logic [BIN_W-1:0] bin_next
);
   logic [SCR_W-1:0] adj;

   always_comb begin
      adj = scratch;
      for (int i = 0; i < int'(SCR_W / 4); i++) begin
         if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
      {scratch_next, bin_next} = {adj, bin} << 1;
   end
endmodule

// File: rtl/bcd_scan_controller.sv
// Sequential binary-to-BCD converter that holds the result and scans it digit by digit
// onto a shared seven-segment decoder with leading-zero blanking.
module bcd_scan_controller
   import bcd_scan_controller_pkg::*;
#(
   parameter int unsigned BIN_W    = 8,
   parameter int unsigned DIGITS   = 3,
   parameter int unsigned SCAN_DIV = 50000
) (
   input logic                  fr_CLOCK_50,
   input logic                  fr_KEY0,
   bcd_scan_controller_if.slave bus
);
   localparam int unsigned SCR_D = scratch_digits(BIN_W, DIGITS);
   localparam int unsigned SCR_W = 4 * SCR_D;
   localparam int unsigned CNT_W = clog2(BIN_W);
   localparam int unsigned PRE_W = clog2(SCAN_DIV);
   localparam int unsigned IDX_W = clog2(DIGITS);

   function automatic logic [4*DIGITS-1:0] reset_display();
      logic [4*DIGITS-1:0] r;
      r = {DIGITS{BLANK_CODE}};
      r[3:0] = 4'h0;
      return r;
   endfunction

   localparam logic [4*DIGITS-1:0] DISP_RESET = reset_display();
   localparam logic [DIGITS-1:0]   EN_RESET   = ~DIGITS'(1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BIN_W-1:0]    bin_q, bin_d, bin_step;
   logic [SCR_W-1:0]    scr_q, scr_d, scr_step;
   logic                load, in_ready;
   logic [4*DIGITS-1:0] bcd_q;
   logic                ovf_q, ovf_new, done_q, seen_nz;
   logic [4*DIGITS-1:0] disp_q, disp_new, disp_d;
   logic [PRE_W-1:0]    pre_q;
   logic [IDX_W-1:0]    idx_q, idx_next;
   logic                wrap;
   logic [DIGITS-1:0]   en_n_q;
   logic [3:0]          dig_q;

   bcd_scan_controller_dd_bcd_step #(
      .SCR_W (SCR_W),
      .BIN_W (BIN_W)
   ) u_step (
      .scratch      (scr_q),
      .bin          (bin_q),
      .scratch_next (scr_step),
      .bin_next     (bin_step)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bin_d    = bin_q;
      scr_d    = scr_q;
      load     = 1'b0;
      in_ready = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               bin_d   = bus.in_bin;
               scr_d   = '0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            bin_d = bin_step;
            scr_d = scr_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            load    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Overflow and blanking are judged on the finished scratch while in DONE.
   always_comb begin
      ovf_new = 1'b0;
      for (int i = int'(DIGITS); i < int'(SCR_D); i++) ovf_new = ovf_new | (|scr_q[4*i +: 4]);
      seen_nz  = 1'b0;
      disp_new = '0;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         seen_nz = seen_nz | (scr_q[4*i +: 4] != 4'd0);
         disp_new[4*i +: 4] = (seen_nz || i == 0) ? scr_q[4*i +: 4] : BLANK_CODE;
      end
      disp_d = load ? disp_new : disp_q;
   end

   assign wrap     = (pre_q == PRE_W'(SCAN_DIV - 1));
   assign idx_next = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

   always_ff @(posedge fr_CLOCK_50 or negedge fr_KEY0) begin
      if (!fr_KEY0) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bin_q   <= '0;
         scr_q   <= '0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         disp_q  <= DISP_RESET;
         pre_q   <= '0;
         idx_q   <= '0;
         en_n_q  <= EN_RESET;
         dig_q   <= 4'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         scr_q   <= scr_d;
         done_q  <= load;
         disp_q  <= disp_d;
         if (load) begin
            bcd_q <= scr_q[4*DIGITS-1:0];
            ovf_q <= ovf_new;
         end
         // A wrap coinciding with the load picks from the freshly loaded display.
         if (wrap) begin
            pre_q  <= '0;
            idx_q  <= idx_next;
            en_n_q <= ~(DIGITS'(1) << idx_next);
            dig_q  <= disp_d[4*idx_next +: 4];
         end else begin
            pre_q <= pre_q + PRE_W'(1);
         end
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.done     = done_q;
   assign bus.ovf      = ovf_q;
   assign bus.bcd_out  = bcd_q;
   assign bus.dig_bcd  = dig_q;
   assign bus.dig_en_n = en_n_q;
endmodule
